led_fader: RTL

//   Downstream of the start-up LED animator. Takes its 8-bit on/off pattern
//   and drives the LED pins with PWM so that each LED fades out instead of

---
 rtl/led_fader.sv | 68 ++++++
 1 files changed

// File: rtl/led_fader.sv
// PWM afterglow driver: each LED jumps to max_level while its input is held,
// then decays linearly to dark at a fixed tick rate once the input drops.
module led_fader #(
  parameter int N_LEDS     = 8,
  parameter int DECAY_DIV  = 20000,
  parameter int DECAY_STEP = 8
) (
  input  logic              clock,
  input  logic              reset_b,
  input  logic [N_LEDS-1:0] leds_in,
  input  logic              enable,
  input  logic [7:0]        max_level,
  output logic [N_LEDS-1:0] pins_out
);

  localparam int              DIV_W    = $clog2(DECAY_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DECAY_DIV - 1);
  localparam logic [7:0]       STEP     = 8'(DECAY_STEP);

  logic [N_LEDS-1:0] inR_q;
  logic [DIV_W-1:0]  divCnt_q, divCnt_d;
  logic [7:0]        pwmCnt_q;
  logic [7:0]        level_q [N_LEDS];
  logic [7:0]        level_d [N_LEDS];
  logic [N_LEDS-1:0] pins_q, pins_d;
  logic              tick;

  // Load beats decay on a shared tick; decay saturates at zero instead of wrapping.
  always_comb begin
    tick     = (divCnt_q == DIV_LAST);
    divCnt_d = tick ? '0 : divCnt_q + 1'b1;
    pins_d   = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      level_d[i] = level_q[i];
      if (!enable) begin
        level_d[i] = 8'd0;
      end else if (inR_q[i]) begin
        level_d[i] = max_level;
      end else if (tick) begin
        level_d[i] = (level_q[i] > STEP) ? level_q[i] - STEP : 8'd0;
      end
      pins_d[i] = enable & (pwmCnt_q < level_q[i]);
    end
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      inR_q    <= '0;
      divCnt_q <= '0;
      pwmCnt_q <= 8'd0;
      pins_q   <= '0;
      for (int i = 0; i < N_LEDS; i++) begin
        level_q[i] <= 8'd0;
      end
    end else begin
      inR_q    <= leds_in;
      divCnt_q <= divCnt_d;
      pwmCnt_q <= pwmCnt_q + 8'd1;
      pins_q   <= pins_d;
      for (int i = 0; i < N_LEDS; i++) begin
        level_q[i] <= level_d[i];
      end
    end
  end

  assign pins_out = pins_q;

endmodule
